sprite_evaluator: RTL

SPRITE_EVALUATOR -- requirements
Module: sprite_evaluator

---
 rtl/ppu_sprite_pkg.sv | 19 +
 rtl/sprite_range_check.sv | 17 +
 rtl/sprite_evaluator.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ppu_sprite_pkg.sv
// Shared types and constants for the PPU sprite evaluation logic.
package ppu_sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    EVAL,
    OVF_SCAN,
    DONE
  } eval_state_t;

  localparam int OAM_ENTRIES_DEF = 64;
  localparam int SEC_SLOTS_DEF   = 8;
  localparam int SPRITE_H8       = 8;
  localparam int SPRITE_H16      = 16;

  localparam logic [7:0] SEC_EMPTY = 8'hFF;

endpackage

// File: rtl/sprite_range_check.sv
// Combinational test of whether a sprite Y position covers the current scanline.
module sprite_range_check
  import ppu_sprite_pkg::*;
(
  input  logic [8:0] scanline,
  input  logic [7:0] Y,
  input  logic       h16,
  output logic       hit
);

  logic [8:0] w_diff;

  // Sprites above the line wrap to a large unsigned value and fail both limits.
  assign w_diff = scanline - {1'b0, Y};
  assign hit    = h16 ? (w_diff < 9'(SPRITE_H16)) : (w_diff < 9'(SPRITE_H8));

endmodule

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, copies in-range sprites, flags overflow.
// Define SPRITE_OVERFLOW_BUG_EN to reproduce the diagonal byte walk of the original overflow scan.
module sprite_evaluator
  import ppu_sprite_pkg::*;
#(
  parameter int OAM_ENTRIES = OAM_ENTRIES_DEF,
  parameter int SEC_SLOTS   = SEC_SLOTS_DEF
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       clock_EN,
  input  logic [8:0] dot,
  input  logic [8:0] scanline,
  input  logic       render_en,
  input  logic       sprite_h16,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_data,
  output logic [4:0] sec_addr,
  output logic [7:0] sec_wdata,
  output logic       sec_write,
  output logic [3:0] sprite_count,
  output logic       sprite0_next,
  output logic       sprite_overflow
);

  localparam int N_W    = $clog2(OAM_ENTRIES);
  localparam int SLOT_W = $clog2(SEC_SLOTS);
  localparam logic [N_W-1:0] N_LAST     = N_W'(OAM_ENTRIES - 1);
  localparam logic [SLOT_W:0] SLOT_LAST = (SLOT_W + 1)'(SEC_SLOTS - 1);

  eval_state_t r_state;
  eval_state_t w_stateNext;

  logic [N_W-1:0]  r_n, w_nNext, w_nInc;
  logic [1:0]      r_m, w_mNext;
  logic [SLOT_W:0] r_slot, w_slotNext;
  logic            r_s0, w_s0Next;
  logic [7:0]      r_latch;
  logic [3:0]      r_spriteCount;
  logic            r_sprite0Next;
  logic            r_overflow;

  logic       w_qual;
  logic       w_hit;
  logic       w_latchEn;
  logic       w_latchOut;
  logic       w_setOvf;
  logic       w_secWrite;
  logic [4:0] w_secAddr;
  logic [7:0] w_secWdata;
  logic [7:0] w_oamAddr;

  assign w_qual = render_en && (scanline <= 9'd239);
  assign w_nInc = (r_n == N_LAST) ? '0 : r_n + 1'b1;

  sprite_range_check u_rangeCheck (
    .scanline (scanline),
    .Y        (r_latch),
    .h16      (sprite_h16),
    .hit      (w_hit)
  );

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_state <= IDLE;
    end else if (clock_EN) begin
      r_state <= w_stateNext;
    end
  end

  // Odd dots fetch from primary OAM; even dots act on the fetched byte.
  always_comb begin
    w_stateNext = r_state;
    w_nNext     = r_n;
    w_mNext     = r_m;
    w_slotNext  = r_slot;
    w_s0Next    = r_s0;
    w_latchEn   = 1'b0;
    w_latchOut  = 1'b0;
    w_setOvf    = 1'b0;
    w_secWrite  = 1'b0;
    w_secAddr   = '0;
    w_secWdata  = '0;
    w_oamAddr   = '0;

    if (!w_qual) begin
      w_stateNext = IDLE;
    end else if (dot == 9'd257) begin
      w_stateNext = IDLE;
      w_latchOut  = (r_state != IDLE);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (dot == 9'd1) begin
            w_stateNext = CLEAR;
            w_nNext     = '0;
            w_mNext     = '0;
            w_slotNext  = '0;
            w_s0Next    = 1'b0;
          end
        end
        CLEAR: begin
          if (!dot[0]) begin
            w_secWrite = 1'b1;
            w_secWdata = SEC_EMPTY;
            w_secAddr  = 5'(dot[8:1] - 8'd1);
          end
          if (dot == 9'd64) w_stateNext = EVAL;
        end
        EVAL: begin
          w_oamAddr = 8'({r_n, r_m});
          if (dot[0]) begin
            w_latchEn = 1'b1;
          end else begin
            w_secWrite = 1'b1;
            w_secWdata = r_latch;
            w_secAddr  = 5'({r_slot[SLOT_W-1:0], r_m});
            if (r_m == 2'd0 && !w_hit) begin
              w_nNext = w_nInc;
              if (r_n == N_LAST) w_stateNext = DONE;
            end else begin
              if (r_m == 2'd0 && r_n == '0) w_s0Next = 1'b1;
              w_mNext = r_m + 2'd1;
              if (r_m == 2'd3) begin
                w_nNext    = w_nInc;
                w_slotNext = r_slot + 1'b1;
                if (r_n == N_LAST) w_stateNext = DONE;
                else if (r_slot == SLOT_LAST) w_stateNext = OVF_SCAN;
              end
            end
          end
        end
        OVF_SCAN: begin
          w_oamAddr = 8'({r_n, r_m});
          if (dot[0]) begin
            w_latchEn = 1'b1;
          end else if (w_hit) begin
            w_setOvf    = 1'b1;
            w_stateNext = DONE;
          end else begin
            w_nNext = w_nInc;
`ifdef SPRITE_OVERFLOW_BUG_EN
            w_mNext = r_m + 2'd1;
`else
            w_mNext = 2'd0;
`endif
            if (r_n == N_LAST) w_stateNext = DONE;
          end
        end
        DONE: begin
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // The overflow flag survives evaluation and is only cleared at the start of the pre-render line.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_n           <= '0;
      r_m           <= '0;
      r_slot        <= '0;
      r_s0          <= 1'b0;
      r_latch       <= '0;
      r_spriteCount <= '0;
      r_sprite0Next <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (clock_EN) begin
      r_n    <= w_nNext;
      r_m    <= w_mNext;
      r_slot <= w_slotNext;
      r_s0   <= w_s0Next;
      if (w_latchEn) r_latch <= oam_data;
      if (w_latchOut) begin
        r_spriteCount <= 4'(r_slot);
        r_sprite0Next <= r_s0;
      end
      if (scanline == 9'd261 && dot == 9'd1) r_overflow <= 1'b0;
      else if (w_setOvf) r_overflow <= 1'b1;
    end
  end

  assign oam_addr        = w_oamAddr;
  assign sec_write       = w_secWrite & clock_EN;
  assign sec_addr        = w_secAddr;
  assign sec_wdata       = w_secWdata;
  assign sprite_count    = r_spriteCount;
  assign sprite0_next    = r_sprite0Next;
  assign sprite_overflow = r_overflow;

endmodule
